// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver that turns ASCII drive letters into a 3-bit valid/ready command.
// Define CMD_WATCHDOG_EN to build the link watchdog, which injects STOP after a silent link.
module uart_cmd_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned TIMEOUT_MS = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_in,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       frame_err,
    output logic       bad_char,
    output logic       overrun,
    output logic       timeout
);
    localparam int unsigned     CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned     HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned     CW           = $clog2(CLKS_PER_BIT);
    localparam longint unsigned WD_CYCLES    = 64'(TIMEOUT_MS) * 64'(CLK_FREQ) / 64'd1000;

    if (CLKS_PER_BIT < 4 || WD_CYCLES < 1) begin : g_param_check
        $error("uart_cmd_rx: CLKS_PER_BIT must be >= 4 and the watchdog period non-zero");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          sync_q, rx_s;
    logic          stop_ok, stop_bad;
    logic          hit, byte_load, load, wd_fire, valid_d;
    logic [2:0]    code, cmd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_q <= uart_in;
            rx_s   <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            rx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            rx_byte_q <= rx_byte_d;
        end
    end

    // The detect cycle counts as the first half-bit cycle, so the start sample lands
    // HALF_BIT cycles after rx_s first goes low.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_d     = bit_q;
        rx_byte_d = rx_byte_q;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = CW'(1);
                    bit_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CW'(HALF_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d     = '0;
                    rx_byte_d = {rx_s, rx_byte_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        stop_ok = 1'b1;
                        state_d = StIdle;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = StBreak;
                    end
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hit  = 1'b1;
        code = 3'd0;
        case (rx_byte_q)
            8'h53:   code = 3'd0;
            8'h46:   code = 3'd1;
            8'h42:   code = 3'd2;
            8'h4C:   code = 3'd3;
            8'h52:   code = 3'd4;
            default: hit  = 1'b0;
        endcase
    end

    // A load in the same cycle as a transfer keeps cmd_valid high and is not an overrun.
    always_comb begin
        byte_load = stop_ok && hit;
        load      = byte_load || wd_fire;
        cmd_d     = cmd;
        valid_d   = cmd_valid;
        if (cmd_valid && cmd_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            cmd_d   = byte_load ? code : 3'd0;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd       <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            bad_char  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cmd       <= cmd_d;
            cmd_valid <= valid_d;
            frame_err <= stop_bad;
            bad_char  <= stop_ok && !hit;
            overrun   <= load && cmd_valid && !cmd_ready;
        end
    end

`ifdef CMD_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WD_CYCLES + 1);

    logic [WW-1:0] wd_cnt_q;
    logic          wd_armed_q;

    // A mapped byte arriving on the expiry cycle wins and re-arms instead.
    assign wd_fire = wd_armed_q && (wd_cnt_q == WW'(WD_CYCLES - 1)) && !byte_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q   <= '0;
            wd_armed_q <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            timeout <= wd_fire;
            if (byte_load) begin
                wd_cnt_q   <= '0;
                wd_armed_q <= 1'b1;
            end else if (wd_fire) begin
                wd_cnt_q   <= '0;
                wd_armed_q <= 1'b0;
            end else if (wd_armed_q) begin
                wd_cnt_q <= wd_cnt_q + WW'(1);
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Testbench for uart_cmd_rx: directed scenarios plus randomized frames checked
// against a letter-lookup reference model of the command link.
module tb_uart_cmd_rx;
    localparam int unsigned CLK_FREQ   = 1_000_000;
    localparam int unsigned BAUD       = 100_000;
    localparam int unsigned TIMEOUT_MS = 1;
    localparam int          BIT_CYC    = 10;
    localparam int          LATENCY    = 97;
    localparam int          WD_CYC     = 1000;

    localparam int EvXfer = 0;
    localparam int EvBad  = 1;
    localparam int EvFerr = 2;
    localparam int EvOvr  = 3;
    localparam int EvTmo  = 4;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       uart_in   = 1'b1;
    logic       cmd_ready = 1'b0;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       frame_err;
    logic       bad_char;
    logic       overrun;
    logic       timeout;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  valid_hi = 0;
    ev_t evq[$];

    uart_cmd_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_in  (uart_in),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .frame_err(frame_err),
        .bad_char (bad_char),
        .overrun  (overrun),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: transfers and pulses, tagged with the posedge count.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid) valid_hi++;
            if (cmd_valid && cmd_ready) evq.push_back(ev_t'{EvXfer, int'(cmd), cyc});
            if (bad_char) evq.push_back(ev_t'{EvBad, 0, cyc});
            if (frame_err) evq.push_back(ev_t'{EvFerr, 0, cyc});
            if (overrun) evq.push_back(ev_t'{EvOvr, 0, cyc});
            if (timeout) evq.push_back(ev_t'{EvTmo, 0, cyc});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at time %0t, required finish", $time);
        $fatal(1, "global time limit reached");
    end

    // Reference model: index of the byte in the drive-letter table, or -1.
    function automatic int ref_code(input logic [7:0] b);
        string cmap = "SFBLR";
        ref_code = -1;
        for (int i = 0; i < 5; i++) begin
            if (cmap[i] == b) ref_code = i;
        end
    endfunction

    function automatic ev_t get_ev(input int idx);
        if (idx < evq.size()) return evq[idx];
        return ev_t'{-1, -1, -1};
    endfunction

    task automatic wait_cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_in = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            wait_cyc(BIT_CYC);
        end
        uart_in = stop;
        wait_cyc(BIT_CYC);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        uart_in = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(4);
    endtask

    task automatic clear_mon();
        evq.delete();
        valid_hi = 0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        uart_in   = 1'b1;
        cmd_ready = 1'b0;
        wait_cyc(3);
        checks++;
        if ({cmd, cmd_valid, frame_err, bad_char, overrun, timeout} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got %b, expected 00000000",
                     {cmd, cmd_valid, frame_err, bad_char, overrun, timeout});
        end
        rst_n = 1'b1;
        clear_mon();
        wait_cyc(30);
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL reset_idle_events: got %0d events, expected 0", evq.size());
        end
        checks++;
        if (cmd !== 3'd0 || cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_cmd: got cmd=%0d valid=%b, expected cmd=0 valid=0",
                     cmd, cmd_valid);
        end
    endtask

    task automatic test_good_byte();
        int  fall_cyc;
        ev_t e;
        do_reset();
        cmd_ready = 1'b1;
        clear_mon();
        fall_cyc = cyc;
        send_frame(8'h46, 1'b1);
        wait_cyc(20);
        e = get_ev(0);
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL good_byte_count: got %0d events, expected 1", evq.size());
        end
        checks++;
        if (e.kind != EvXfer || e.val != 1) begin
            failures++;
            $display("FAIL good_byte_cmd: got kind=%0d cmd=%0d, expected kind=%0d cmd=1",
                     e.kind, e.val, EvXfer);
        end
        checks++;
        if (e.cyc - fall_cyc != LATENCY) begin
            failures++;
            $display("FAIL good_byte_latency: got %0d cycles, expected %0d",
                     e.cyc - fall_cyc, LATENCY);
        end
        checks++;
        if (valid_hi != 1) begin
            failures++;
            $display("FAIL good_byte_valid_width: got %0d cycles, expected 1", valid_hi);
        end
    endtask

    task automatic test_unmapped_glitch();
        int  fall_cyc;
        ev_t e;
        do_reset();
        cmd_ready = 1'b1;
        clear_mon();
        send_frame(8'h41, 1'b1);
        wait_cyc(20);
        e = get_ev(0);
        checks++;
        if (evq.size() != 1 || e.kind != EvBad) begin
            failures++;
            $display("FAIL unmapped_bad_char: got %0d events first kind=%0d, expected 1 kind=%0d",
                     evq.size(), e.kind, EvBad);
        end
        checks++;
        if (valid_hi != 0) begin
            failures++;
            $display("FAIL unmapped_no_valid: got %0d valid cycles, expected 0", valid_hi);
        end
        clear_mon();
        uart_in = 1'b0;
        wait_cyc(3);
        uart_in = 1'b1;
        wait_cyc(30);
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL glitch_no_flags: got %0d events, expected 0", evq.size());
        end
        fall_cyc = cyc;
        send_frame(8'h52, 1'b1);
        wait_cyc(20);
        e = get_ev(0);
        checks++;
        if (evq.size() != 1 || e.kind != EvXfer || e.val != 4 || e.cyc - fall_cyc != LATENCY) begin
            failures++;
            $display("FAIL glitch_then_byte: got n=%0d kind=%0d cmd=%0d lat=%0d, expected n=1 kind=0 cmd=4 lat=%0d",
                     evq.size(), e.kind, e.val, e.cyc - fall_cyc, LATENCY);
        end
    endtask

    task automatic test_frame_err();
        int  fall_cyc;
        ev_t e0;
        ev_t e1;
        do_reset();
        cmd_ready = 1'b1;
        clear_mon();
        fall_cyc = cyc;
        send_frame(8'h53, 1'b0);
        wait_cyc(50);
        uart_in = 1'b1;
        wait_cyc(10);
        send_frame(8'h52, 1'b1);
        wait_cyc(20);
        e0 = get_ev(0);
        e1 = get_ev(1);
        checks++;
        if (evq.size() != 2) begin
            failures++;
            $display("FAIL frame_err_count: got %0d events, expected 2", evq.size());
        end
        checks++;
        if (e0.kind != EvFerr || e0.cyc - fall_cyc != LATENCY) begin
            failures++;
            $display("FAIL frame_err_pulse: got kind=%0d lat=%0d, expected kind=%0d lat=%0d",
                     e0.kind, e0.cyc - fall_cyc, EvFerr, LATENCY);
        end
        checks++;
        if (e1.kind != EvXfer || e1.val != 4) begin
            failures++;
            $display("FAIL frame_err_recover: got kind=%0d cmd=%0d, expected kind=0 cmd=4",
                     e1.kind, e1.val);
        end
    endtask

    task automatic test_overrun();
        int  fall_cyc;
        ev_t e;
        do_reset();
        cmd_ready = 1'b0;
        clear_mon();
        fall_cyc = cyc;
        send_frame(8'h4C, 1'b1);
        checks++;
        if (cmd !== 3'd3 || cmd_valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_first_held: got cmd=%0d valid=%b, expected cmd=3 valid=1",
                     cmd, cmd_valid);
        end
        send_frame(8'h42, 1'b1);
        wait_cyc(5);
        e = get_ev(0);
        checks++;
        if (evq.size() != 1 || e.kind != EvOvr || e.cyc - fall_cyc != LATENCY + 100) begin
            failures++;
            $display("FAIL overrun_pulse: got n=%0d kind=%0d at=%0d, expected n=1 kind=%0d at=%0d",
                     evq.size(), e.kind, e.cyc - fall_cyc, EvOvr, LATENCY + 100);
        end
        checks++;
        if (cmd !== 3'd2 || cmd_valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_latest_held: got cmd=%0d valid=%b, expected cmd=2 valid=1",
                     cmd, cmd_valid);
        end
        cmd_ready = 1'b1;
        wait_cyc(5);
        e = get_ev(1);
        checks++;
        if (evq.size() != 2 || e.kind != EvXfer || e.val != 2) begin
            failures++;
            $display("FAIL overrun_transfer: got n=%0d kind=%0d cmd=%0d, expected n=2 kind=0 cmd=2",
                     evq.size(), e.kind, e.val);
        end
        checks++;
        if (cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_valid_clear: got %b, expected 0", cmd_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int         fall_cyc;
        ev_t        e;
        b = 8'h46;
        do_reset();
        cmd_ready = 1'b0;
        clear_mon();
        send_frame(8'h52, 1'b1);
        checks++;
        if (cmd !== 3'd4 || cmd_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre_held: got cmd=%0d valid=%b, expected cmd=4 valid=1",
                     cmd, cmd_valid);
        end
        uart_in = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            uart_in = b[i];
            wait_cyc(BIT_CYC);
        end
        uart_in = b[4];
        wait_cyc(5);
        rst_n   = 1'b0;
        uart_in = 1'b1;
        wait_cyc(2);
        checks++;
        if ({cmd, cmd_valid, frame_err, bad_char, overrun, timeout} !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %b, expected 00000000",
                     {cmd, cmd_valid, frame_err, bad_char, overrun, timeout});
        end
        wait_cyc(3);
        rst_n     = 1'b1;
        cmd_ready = 1'b1;
        clear_mon();
        wait_cyc(30);
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_no_garbage: got %0d events, expected 0", evq.size());
        end
        fall_cyc = cyc;
        send_frame(8'h42, 1'b1);
        wait_cyc(20);
        e = get_ev(0);
        checks++;
        if (evq.size() != 1 || e.kind != EvXfer || e.val != 2 || e.cyc - fall_cyc != LATENCY) begin
            failures++;
            $display("FAIL reset_mid_next_byte: got n=%0d kind=%0d cmd=%0d lat=%0d, expected n=1 kind=0 cmd=2 lat=%0d",
                     evq.size(), e.kind, e.val, e.cyc - fall_cyc, LATENCY);
        end
    endtask

    task automatic test_watchdog();
        ev_t e0;
        ev_t e1;
        ev_t e2;
        do_reset();
        cmd_ready = 1'b1;
        clear_mon();
        wait_cyc(1500);
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL watchdog_disarmed_at_reset: got %0d events, expected 0", evq.size());
        end
        send_frame(8'h46, 1'b1);
        wait_cyc(WD_CYC + 3000);
        e0 = get_ev(0);
        e1 = get_ev(1);
        e2 = get_ev(2);
        checks++;
        if (e0.kind != EvXfer || e0.val != 1) begin
            failures++;
            $display("FAIL watchdog_first_cmd: got kind=%0d cmd=%0d, expected kind=0 cmd=1",
                     e0.kind, e0.val);
        end
`ifdef CMD_WATCHDOG_EN
        checks++;
        if (evq.size() != 3) begin
            failures++;
            $display("FAIL watchdog_count: got %0d events, expected 3", evq.size());
        end
        checks++;
        if (e1.kind != EvXfer || e1.val != 0 || e1.cyc - e0.cyc != WD_CYC) begin
            failures++;
            $display("FAIL watchdog_stop_cmd: got kind=%0d cmd=%0d after=%0d, expected kind=0 cmd=0 after=%0d",
                     e1.kind, e1.val, e1.cyc - e0.cyc, WD_CYC);
        end
        checks++;
        if (e2.kind != EvTmo || e2.cyc != e1.cyc) begin
            failures++;
            $display("FAIL watchdog_timeout_pulse: got kind=%0d at=%0d, expected kind=%0d at=%0d",
                     e2.kind, e2.cyc, EvTmo, e1.cyc);
        end
`else
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL watchdog_off_count: got %0d events (second kind=%0d), expected 1",
                     evq.size(), e1.kind);
        end
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL watchdog_off_timeout: got %b, expected 0", timeout);
        end
`endif
    endtask

    task automatic test_random();
        ev_t        expq[$];
        string      cmap = "SFBLR";
        logic [7:0] b;
        logic       stop;
        int         code;
        ev_t        e;
        do_reset();
        cmd_ready = 1'b1;
        clear_mon();
        for (int n = 0; n < 40; n++) begin
            // Every fourth frame is a clean letter so the link never goes silent long.
            if (n % 4 == 3 || $urandom_range(0, 9) < 6) b = cmap[$urandom_range(0, 4)];
            else b = 8'($urandom_range(0, 255));
            stop = (n % 4 == 3) ? 1'b1 : ($urandom_range(0, 9) != 0);
            code = ref_code(b);
            if (!stop) expq.push_back(ev_t'{EvFerr, 0, 0});
            else if (code < 0) expq.push_back(ev_t'{EvBad, 0, 0});
            else expq.push_back(ev_t'{EvXfer, code, 0});
            send_frame(b, stop);
            if (!stop) begin
                wait_cyc($urandom_range(0, 30));
                uart_in = 1'b1;
                wait_cyc($urandom_range(2, 12));
            end else begin
                wait_cyc($urandom_range(0, 12));
            end
        end
        wait_cyc(20);
        checks++;
        if (evq.size() != expq.size()) begin
            failures++;
            $display("FAIL random_count: got %0d events, expected %0d", evq.size(), expq.size());
        end
        for (int i = 0; i < expq.size(); i++) begin
            e = get_ev(i);
            checks++;
            if (e.kind != expq[i].kind || e.val != expq[i].val) begin
                failures++;
                $display("FAIL random_frame_%0d: got kind=%0d cmd=%0d, expected kind=%0d cmd=%0d",
                         i, e.kind, e.val, expq[i].kind, expq[i].val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_byte();
        test_unmapped_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        test_watchdog();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
